// File: rtl/binarize_pool_pkg.sv
// Shared constants and types for the binarize/pool stage that follows the
// binary convolution layer.
package binarize_pool_pkg;

  // Width of one signed convolution sample.
  localparam int SAMPLE_W = 5;

  // Layer geometry: input size, conv output size, kernel size.
  localparam int NI_L1 = 28;
  localparam int NI_L2 = 12;
  localparam int K     = 3;
  localparam int WO_L1 = NI_L1 - K + 1;  // 26
  localparam int WO_L2 = NI_L2 - K + 1;  // 10

  // Pooled (2x2, stride 2) output sizes.
  localparam int WP_L1 = WO_L1 / 2;      // 13
  localparam int WP_L2 = WO_L2 / 2;      // 5

  typedef logic signed [SAMPLE_W-1:0] conv_t;

endpackage

// File: rtl/binarize_pool_if.sv
// Sample stream in / pooled pixel stream out.
// master = conv-stage side (drives samples), slave = pooling block.
interface binarize_pool_if #(
  parameter int DW = 5
);
  logic signed [DW-1:0] din;
  logic                 ivalid;
  logic                 done_in;
  logic                 dout;
  logic                 ovalid;
  logic                 done;

  modport master (
    output din, ivalid, done_in,
    input  dout, ovalid, done
  );

  modport slave (
    input  din, ivalid, done_in,
    output dout, ovalid, done
  );
endinterface

// File: rtl/pool_rowbuf.sv
// One bit per horizontal pair of the previous (even) row: holds the
// horizontal max until the odd row below arrives to finish the 2x2 window.
module pool_rowbuf #(
  parameter int DEPTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic          wdata,
  output logic          rdata
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic             idx_ok;

  assign idx_ok = (int'(idx) < DEPTH);

  // Asynchronous read of the addressed pair result.
  always_comb begin
    rdata = 1'b0;
    if (idx_ok) rdata = mem_q[idx];
  end

  // Next-state of the array: write one entry when enabled.
  always_comb begin
    // NOTE: assign a default first so every path drives mem_d and no latch is inferred.
    mem_d = mem_q;
    if (we && idx_ok) mem_d[idx] = wdata;
  end

  // Array register; small enough to live in flops, so it is cleared on reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: this array is flops, not RAM, so resetting it is cheap and deterministic.
    if (!rstn) mem_q <= '0;
    else       mem_q <= mem_d;
  end

endmodule

// File: rtl/binarize_pool.sv
// Sign/threshold activation followed by 2x2 stride-2 max pooling on bits.
// Samples arrive row-major, one per ivalid cycle; one pooled bit leaves one
// cycle after each odd-row/odd-column sample is accepted.
module binarize_pool
  import binarize_pool_pkg::*;
#(
  parameter int DW     = 5,
  parameter int WO_MAX = 26
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state,
  input  logic signed [DW-1:0] thr,
  binarize_pool_if.slave       bus
);

  localparam int CW = $clog2(WO_MAX);
  localparam int BW = $clog2(WO_MAX / 2);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          pair_q, pair_d;
  logic          dout_q, dout_d;
  logic          ovalid_q, ovalid_d;
  logic          done_q, done_d;

  logic [CW-1:0] wo_last;
  logic          act_bit;
  logic          h_max;
  logic          rb_we;
  logic [BW-1:0] rb_idx;
  logic          rb_rdata;
  logic          col_end;
  logic          row_end;

  // Last column/row index for the selected layer.
  assign wo_last = state ? CW'(WO_L2 - 1) : CW'(WO_L1 - 1);

  // Activation: full signed compare against the threshold.
  assign act_bit = (bus.din >= thr);

  // Horizontal max of the current pair (meaningful on odd columns).
  assign h_max   = pair_q | act_bit;

  assign col_end = (col_q == wo_last);
  assign row_end = (row_q == wo_last);
  assign rb_idx  = BW'(col_q >> 1);
  assign rb_we   = bus.ivalid & col_q[0] & ~row_q[0];

  pool_rowbuf #(
    .DEPTH (WO_MAX / 2),
    .AW    (BW)
  ) u_rowbuf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (rb_we),
    .idx   (rb_idx),
    .wdata (h_max),
    .rdata (rb_rdata)
  );

  // Counter advance, pair latch, pooled output and end-of-frame detection.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    pair_d   = pair_q;
    dout_d   = dout_q;
    ovalid_d = 1'b0;
    done_d   = 1'b0;

    if (bus.ivalid) begin
      if (!col_q[0]) begin
        pair_d = act_bit;
      end else if (row_q[0]) begin
        dout_d   = rb_rdata | h_max;
        ovalid_d = 1'b1;
      end

      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Frame resync from the conv stage wins over counter advance.
    if (bus.done_in) begin
      col_d  = '0;
      row_d  = '0;
      pair_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rstn) begin
      col_q    <= '0;
      row_q    <= '0;
      pair_q   <= 1'b0;
      dout_q   <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      pair_q   <= pair_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.ovalid = ovalid_q;
  assign bus.done   = done_q;

endmodule
